mp_addsub: RTL
==============

# mp_addsub

Iterative multi-precision adder/subtractor: the parametrised successor to `mp_adder`. It processes `OPERAND_WIDTH`-bit operands in `ADDER_WIDTH`-bit chunks, one chunk per clock, and selects add or subtract per operation. It also reports busy status. It sits in the arithmetic accelerator datapath as the shared add/sub primitive for the modular-arithmetic blocks.

## Interface
- `OPERAND_WIDTH`, default 128: operand width. Must be an integer multiple of `ADDER_WIDTH`.
- `ADDER_WIDTH`, default 16: chunk width processed per cycle. Must satisfy 1 ≤ `ADDER_WIDTH` ≤ `OPERAND_WIDTH`.
- Derived: `N = OPERAND_WIDTH/ADDER_WIDTH` chunks. The chunk counter is `max(1, clog2(N))` bits.

Ports:
- `iClk` input 1: the single clock, rising-edge.
- `iRstN` input 1: reset, asynchronous, active-low.
- `iStart` input 1: operation request, sampled on the rising edge.
- `iSub` input 1: 0 selects A+B, 1 selects A−B. Sampled with `iStart`.
- `iOpA` input `OPERAND_WIDTH`: operand A. Sampled with `iStart`.
- `iOpB` input `OPERAND_WIDTH`: operand B. Sampled with `iStart`.
- `oRes` output `OPERAND_WIDTH+1`: result. Bit `OPERAND_WIDTH` is the carry for add and the borrow for subtract.
- `oDone` output 1: one-cycle pulse indicating `oRes` is valid.
- `oBusy` output 1: high while an operation is in progress.
- `oOvf` output 1: signed overflow flag. Present only with `MP_ADDSUB_OVF_EN`.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE or DONE, with `iStart`=1:**
  - Latch A.
  - Latch B, or ~B when `iSub`=1.
  - Set the carry register to `iSub`.
  - Clear the chunk counter and go to CALC.
- **IDLE or DONE, with `iStart`=0:** go to or stay in IDLE. `oRes` holds its last value.
- **CALC, each cycle:**
  - Compute `{c, s} = A[ADDER_WIDTH-1:0] + B[ADDER_WIDTH-1:0] + carry`.
  - Shift A and B right by `ADDER_WIDTH`.
  - Shift `s` into the result register from the MSB end.
  - Set carry to `c` and increment the counter.
  - When counter = N−1, go to DONE.
- **DONE:**
  - `oDone`=1.
  - `oRes = {final, result}`, where `final` = carry for add and ~carry for subtract.
  - Subtract results are two's complement mod 2^`OPERAND_WIDTH`, and bit `OPERAND_WIDTH` = 1 iff A<B (unsigned).
- **`iStart` while in CALC:** ignored. The operation in flight is not disturbed.
- **Input changes while `oBusy`=1:** `iOpA`, `iOpB` and `iSub` are don't-care.
- **`oRes` validity:** read it only while `oDone`=1. Its value is stable after DONE until the next accepted `iStart`. Intermediate values during CALC are undefined to the consumer.

## Timing
- **Reset values:**
  - `oRes`=0, `oDone`=0, `oBusy`=0, `oOvf`=0.
  - State IDLE, counter 0, operand and carry registers 0.
- **Reset mid-operation:** asserting `iRstN` during CALC or DONE aborts immediately and asynchronously to the values above. No `oDone` is produced for the aborted operation.
- **Latency:** if the start is accepted at edge E0, then:
  - `oBusy`=1 after E0 through edge E_N.
  - `oDone`=1 for exactly the one cycle after edge E_N.
  - Default parameters: N=8, so there are 8 cycles from acceptance to `oDone`.
- **Back-to-back operation:** a new `iStart` is accepted in the `oDone` cycle. `oBusy` is 0 during DONE, giving one operation per N+1 cycles.
- **N=1 (`ADDER_WIDTH`=`OPERAND_WIDTH`):** a single CALC cycle, then DONE.

## Configuration
- Macro `MP_ADDSUB_OVF_EN`.
- **Defined:**
  - Port `oOvf` exists.
  - In DONE, `oOvf` = carry into the operand MSB XOR carry out of the operand MSB, i.e. two's-complement signed overflow of A±B.
  - `oOvf` updates together with `oRes`, holds with it, and resets to 0.
- **Undefined:**
  - Port `oOvf` and its logic are absent.
  - All other behaviour and timing are identical.

## Test plan
- **Add:** A=0x12121212_34343434_56565656_78787878, B=0xefefefef_cdcdcdcd_abababab_90909090, `iSub`=0 → `oRes`=0x1_02020202_02020202_02020202_09090908. `oDone` high 8 cycles after acceptance, for one cycle.
- **Subtract with borrow:** A=5, B=7, `iSub`=1 → `oRes`={1, 128'hFFFF…FFFE}. **Subtract without borrow:** A=7, B=5 → `oRes`={0, 128'h2}.
- **Busy and back-to-back:**
  - Pulse `iStart` at 3 and 5 cycles after acceptance, with different operands → ignored; the first result is correct.
  - Assert `iStart` in the `oDone` cycle → a second correct result 9 cycles later.
- **Reset mid-operation:** pulse `iRstN` low asynchronously 4 cycles into CALC → `oRes`=0, `oDone`=0, `oBusy`=0 with no further `oDone`. A subsequent add of 1+1 yields 2.
- **Overflow (`MP_ADDSUB_OVF_EN`):**
  - A=0x7FFF…F, B=1, add → `oOvf`=1, `oRes`={0, 0x8000…0}.
  - A=0x8000…0, B=1, subtract → `oOvf`=1.
  - 5+7 → `oOvf`=0.
- **Parameter sweep:** (`OPERAND_WIDTH`, `ADDER_WIDTH`) = (64,64), (64,8), (256,32), 200 random add/sub vectors each → matches the `{borrow/carry, A±B}` reference model. Latency is N cycles in every case.

Source files
------------

// File: rtl/mp_addsub.sv
// mp_addsub: iterative multi-precision adder/subtractor.
// Operands are consumed ADDER_WIDTH bits per clock, LSB chunk first.
// Optional feature macro: MP_ADDSUB_OVF_EN adds the oOvf signed-overflow output.
module mp_addsub #(
  parameter int unsigned OPERAND_WIDTH = 128,
  parameter int unsigned ADDER_WIDTH   = 16
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iStart,
  input  logic                     iSub,
  input  logic [OPERAND_WIDTH-1:0] iOpA,
  input  logic [OPERAND_WIDTH-1:0] iOpB,
  output logic [OPERAND_WIDTH:0]   oRes,
  output logic                     oDone,
  output logic                     oBusy
`ifdef MP_ADDSUB_OVF_EN
  ,
  output logic                     oOvf
`endif
);

  localparam int unsigned OW    = OPERAND_WIDTH;
  localparam int unsigned AW    = ADDER_WIDTH;
  localparam int unsigned N     = OW / AW;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [OW-1:0]    opA;
  logic [OW-1:0]    opB;
  logic [OW-1:0]    resAcc;
  logic [OW-1:0]    resNext;
  logic             carry;
  logic             subOp;
  logic [CNT_W-1:0] cnt;
  logic [AW:0]      chunkSum;
  logic             lastChunk;
  logic             loadOp;
  logic             stepOp;

  // One chunk of the ripple: low chunk of A plus low chunk of (possibly inverted) B plus carry
  assign chunkSum  = {1'b0, opA[AW-1:0]} + {1'b0, opB[AW-1:0]} + {{AW{1'b0}}, carry};
  // Result accumulator with the new sum chunk entering from the MSB end
  assign resNext   = OW'({chunkSum[AW-1:0], resAcc} >> AW);
  assign lastChunk = (cnt == LAST_CNT);

  // State register
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and datapath strobes; a start during CALC is ignored
  always_comb begin
    stateNext = state;
    loadOp    = 1'b0;
    stepOp    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (iStart) begin
          stateNext = CALC;
          loadOp    = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      CALC: begin
        stepOp = 1'b1;
        if (lastChunk) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand shift registers, carry chain, chunk counter and result capture
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      opA    <= '0;
      opB    <= '0;
      resAcc <= '0;
      carry  <= 1'b0;
      subOp  <= 1'b0;
      cnt    <= '0;
      oRes   <= '0;
`ifdef MP_ADDSUB_OVF_EN
      oOvf   <= 1'b0;
`endif
    end else if (loadOp) begin
      opA   <= iOpA;
      opB   <= iSub ? ~iOpB : iOpB;
      carry <= iSub;
      subOp <= iSub;
      cnt   <= '0;
    end else if (stepOp) begin
      opA    <= opA >> AW;
      opB    <= opB >> AW;
      carry  <= chunkSum[AW];
      resAcc <= resNext;
      cnt    <= cnt + CNT_W'(1);
      if (lastChunk) begin
        // Top bit is carry for add, borrow (inverted carry) for subtract
        oRes <= {subOp ? ~chunkSum[AW] : chunkSum[AW], resNext};
`ifdef MP_ADDSUB_OVF_EN
        // Carry into the MSB is a^b^s at that bit; XOR with carry out gives signed overflow
        oOvf <= opA[AW-1] ^ opB[AW-1] ^ chunkSum[AW-1] ^ chunkSum[AW];
`endif
      end
    end
  end

  // Registered status flags follow the next state
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oBusy <= (stateNext == CALC);
      oDone <= (stateNext == DONE);
    end
  end

endmodule
